// File: rtl/pci_uart_target_ctrl.sv
// PCI target controller for the PCI-UART adapter: claims I/O writes to the data port
// and config writes to the frame-format register, feeding bytes into the UART TX FIFO.
module pci_uart_target_ctrl #(
    parameter logic [31:0] IO_BASE       = 32'h0000_0300,
    parameter int          WAIT_LIMIT    = 16,
    parameter logic [3:0]  STOP_DEFAULT  = 4'd1,
    parameter logic [3:0]  START_DEFAULT = 4'd1
) (
    input  logic        PCI_CLK,
    input  logic        RESET,
    input  logic        FRAME,
    input  logic        IRDY,
    input  logic        IDSEL,
    input  logic [3:0]  CBE,
    input  logic [31:0] AD,
    output logic        DEVSEL,
    output logic        TRDY,
    output logic        STOP,
    input  logic        TXF_FULL,
    output logic        TXF_WR,
    output logic [7:0]  TXF_DATA,
    output logic [3:0]  STOP_BITS,
    output logic [3:0]  START_BITS,
    output logic        BUSY
);

    typedef enum logic [2:0] {
        S_IDLE, S_IGNORE, S_CLAIM, S_DATA, S_DISC, S_RETRY, S_TURN
    } state_t;

    localparam logic [7:0] WAIT_MAX = 8'(WAIT_LIMIT);

    state_t     state, state_nxt;
    logic       frame_q;
    logic       is_cfg, cfg_nxt;
    logic [7:0] wait_cnt, cnt_nxt;
    logic       trdy_nxt, wr_nxt;
    logic [7:0] data_nxt;
    logic [3:0] stop_bits_nxt, start_bits_nxt;

    logic addr_phase, io_hit, cfg_hit, xfer;

    always_comb begin
        addr_phase = !FRAME && frame_q;
        io_hit     = (CBE == 4'b0011) && (AD[31:2] == IO_BASE[31:2]);
        cfg_hit    = (CBE == 4'b1011) && IDSEL;
        xfer       = (state == S_DATA) && !IRDY && !TRDY;
    end

    always_comb begin
        state_nxt      = state;
        cfg_nxt        = is_cfg;
        cnt_nxt        = wait_cnt;
        trdy_nxt       = 1'b1;
        wr_nxt         = 1'b0;
        data_nxt       = TXF_DATA;
        stop_bits_nxt  = STOP_BITS;
        start_bits_nxt = START_BITS;
        case (state)
            S_IDLE: begin
                if (addr_phase) begin
                    if (io_hit || cfg_hit) begin
                        state_nxt = S_CLAIM;
                        cfg_nxt   = cfg_hit;
                        cnt_nxt   = 8'd0;
                    end else begin
                        state_nxt = S_IGNORE;
                    end
                end
            end
            S_IGNORE: if (FRAME && IRDY) state_nxt = S_IDLE;
            S_CLAIM:  state_nxt = S_DATA;
            S_DATA: begin
                if (xfer) begin
                    if (!CBE[0]) begin
                        if (is_cfg) begin
                            stop_bits_nxt  = AD[3:0];
                            start_bits_nxt = AD[7:4];
                        end else begin
                            wr_nxt   = 1'b1;
                            data_nxt = AD[7:0];
                        end
                    end
                    // Only single-phase transfers are accepted; a burst is disconnected.
                    state_nxt = FRAME ? S_TURN : S_DISC;
                end else if (FRAME && IRDY) begin
                    state_nxt = S_TURN;
                end else if (is_cfg || !TXF_FULL) begin
                    trdy_nxt = 1'b0;
                end else begin
                    cnt_nxt = wait_cnt + 8'd1;
                    if (cnt_nxt == WAIT_MAX) state_nxt = S_RETRY;
                end
            end
            S_DISC, S_RETRY: if (FRAME) state_nxt = S_TURN;
            S_TURN: begin
                state_nxt = S_IDLE;
                cnt_nxt   = 8'd0;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge PCI_CLK or negedge RESET) begin
        if (!RESET) begin
            state      <= S_IDLE;
            frame_q    <= 1'b1;
            is_cfg     <= 1'b0;
            wait_cnt   <= 8'd0;
            DEVSEL     <= 1'b1;
            TRDY       <= 1'b1;
            STOP       <= 1'b1;
            TXF_WR     <= 1'b0;
            TXF_DATA   <= 8'd0;
            STOP_BITS  <= STOP_DEFAULT;
            START_BITS <= START_DEFAULT;
            BUSY       <= 1'b0;
        end else begin
            state      <= state_nxt;
            frame_q    <= FRAME;
            is_cfg     <= cfg_nxt;
            wait_cnt   <= cnt_nxt;
            DEVSEL     <= !(state_nxt inside {S_DATA, S_DISC, S_RETRY});
            TRDY       <= (state_nxt == S_DATA) ? trdy_nxt : 1'b1;
            STOP       <= !(state_nxt inside {S_DISC, S_RETRY});
            TXF_WR     <= wr_nxt;
            TXF_DATA   <= data_nxt;
            STOP_BITS  <= stop_bits_nxt;
            START_BITS <= start_bits_nxt;
            BUSY       <= (state_nxt != S_IDLE);
        end
    end

endmodule

// File: doc/pci_uart_target_ctrl.md
Name: pci_uart_target_ctrl

Overview:
PCI target-side transaction controller for the PCI-UART adapter. It decodes PCI bus cycles (FRAME/IRDY/IDSEL/CBE/AD), claims I/O writes to the UART data port and configuration writes to the frame-format register, and drives DEVSEL/TRDY/STOP. Accepted data bytes are pushed into the UART TX FIFO with back-pressure handling and target retry. It owns the STOP_BITS/START_BITS configuration consumed by the UART transmitter.

Parameters:
IO_BASE, 32'h0000_0300, I/O address of the UART data port; decode is AD[31:2]==IO_BASE[31:2].
WAIT_LIMIT, 16, DATA-state cycles with TXF_FULL=1 before the target signals retry (range 2..255).
STOP_DEFAULT, 4'd1, reset value of STOP_BITS.
START_DEFAULT, 4'd1, reset value of START_BITS.

Ports:
PCI_CLK  in  1  PCI clock; all logic on the rising edge.
RESET  in  1  asynchronous, active-low reset.
FRAME  in  1  PCI FRAME#, active low.
IRDY  in  1  PCI IRDY#, active low.
IDSEL  in  1  configuration select, active high.
CBE  in  4  command (address phase) / byte enables, active low (data phase).
AD  in  32  PCI address/data; input only for this block.
DEVSEL  out  1  DEVSEL#, active low.
TRDY  out  1  TRDY#, active low.
STOP  out  1  STOP#, active low.
TXF_FULL  in  1  UART TX FIFO full.
TXF_WR  out  1  one-cycle FIFO write strobe.
TXF_DATA  out  8  byte to FIFO, valid while TXF_WR=1.
STOP_BITS  out  4  configured stop-bit count.
START_BITS  out  4  configured start-bit count.
BUSY  out  1  high whenever state != IDLE.

Behaviour:
- Reset (RESET=0, asynchronous): state=IDLE; DEVSEL=TRDY=STOP=1; TXF_WR=0; TXF_DATA=0; STOP_BITS=STOP_DEFAULT; START_BITS=START_DEFAULT; wait counter=0. Asserting reset mid-transaction abandons it with no FIFO write.
- All outputs are registered.
- Address phase: a rising edge with FRAME=0 and the FRAME sample from the previous edge =1. Latch CBE as the command.
- Claimed commands:
  - I/O write (CBE=4'b0011) with the AD address match.
  - Config write (CBE=4'b1011) with IDSEL=1; AD[10:0] is ignored.
  - Everything else is unclaimed.
- States:
  - IDLE: claimed address phase -> CLAIM; unclaimed -> IGNORE.
  - IGNORE: outputs stay deasserted; when FRAME=1 and IRDY=1 -> IDLE.
  - CLAIM (one cycle): DEVSEL=0 registered, giving medium decode (DEVSEL low on the 2nd edge after the address). Next state is DATA.
  - DATA:
    - DEVSEL=0.
    - TRDY=0 if the command is config write, or TXF_FULL=0; otherwise TRDY=1 and the wait counter increments.
    - Transfer = an edge with IRDY=0 and TRDY=0. On that edge:
      - I/O write with CBE[0]=0: TXF_WR=1 and TXF_DATA=AD[7:0] for exactly the next cycle.
      - Config write with CBE[0]=0: STOP_BITS=AD[3:0], START_BITS=AD[7:4].
      - CBE[0]=1: transfer completes with no side effect.
      - Then: FRAME=1 -> TURN; FRAME=0 (burst attempt) -> DISC.
    - Counter reaches WAIT_LIMIT with no transfer -> RETRY.
    - FRAME=1 and IRDY=1 without a transfer (master abort) -> TURN.
  - DISC: DEVSEL=0, STOP=0, TRDY=1. When FRAME=1 -> TURN. No further data is accepted.
  - RETRY: DEVSEL=0, STOP=0, TRDY=1, no write. When FRAME=1 -> TURN.
  - TURN (one cycle): DEVSEL=TRDY=STOP=1, counter cleared. Next state is IDLE. An address phase during TURN is not decoded, so a back-to-back transaction is missed.
- Timing and side-effect rules:
  - At most one TXF_WR per transaction.
  - TXF_FULL is sampled only in DATA. A FIFO that fills after a write does not affect the current transaction.
  - TXF_FULL deasserting on the same edge the counter hits WAIT_LIMIT-1: TRDY goes low and the transfer wins (no RETRY).
  - STOP_BITS/START_BITS change only on a config-write transfer edge.

Test Plan:
- Reset then I/O write to 0x300, AD=0x000000A5, CBE data=4'b1110, FRAME high in data phase, TXF_FULL=0 -> DEVSEL low 2 edges after address; TRDY low; one TXF_WR pulse with TXF_DATA=0xA5; TURN; BUSY returns low.
- Config write IDSEL=1, AD=0x00000021, CBE data=4'b0000 -> STOP_BITS=1, START_BITS=2; TXF_WR never asserted.
- I/O write to 0x304, and separately a memory write CBE=4'b0111 -> DEVSEL/TRDY/STOP stay high; IGNORE until FRAME and IRDY are high; no TXF_WR.
- TXF_FULL=1 held for the whole transaction, WAIT_LIMIT=16 -> 16 cycles of TRDY=1, then STOP=0 with DEVSEL=0; no write. After FRAME rises, one TURN cycle, then IDLE.
- Burst I/O write (FRAME low across two data phases, bytes 0x11, 0x22) -> only 0x11 written; STOP=0 after the first transfer until FRAME=1.
- RESET pulsed low while in DATA with TXF_FULL=1 -> outputs return to reset values immediately; STOP_BITS=START_BITS=1; no TXF_WR.
